// File: rtl/passcode_checker.sv
// Passcode checker: assembles encoded digits into an entry, unlocks on a match,
// counts failures into a timed lockout, and lets an unlocked user change the code.
module passcode_checker #(
  parameter int DIGITS      = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] code_in,
  input  logic       code_valid,
  input  logic       submit,
  input  logic       clear,
  input  logic       lock,
  output logic       unlocked,
  output logic       locked,
  output logic       error,
  output logic       set_done,
  output logic [3:0] digit_cnt,
  output logic [3:0] tries_left
);

  localparam int       BUF_W      = 5 * DIGITS;
  localparam int       TIMER_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [3:0] DIGITS_N   = 4'(DIGITS);
  localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(LOCK_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(1);

  localparam logic [1:0] ST_ENTRY   = 2'd0;
  localparam logic [1:0] ST_OPEN    = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [1:0]         state;
  logic [BUF_W-1:0]   stored;
  logic [BUF_W-1:0]   entry;
  logic [TIMER_W-1:0] timer;

  logic legal;
  logic entry_full;
  logic entry_match;

  // The encoder only ever emits these ten patterns; anything else is line noise.
  always_comb begin
    legal = 1'b0;
    case (code_in)
      5'b00000, 5'b00001, 5'b10001, 5'b10010, 5'b01010,
      5'b01011, 5'b11011, 5'b11111, 5'b01111, 5'b01110: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign entry_full  = (digit_cnt == DIGITS_N);
  assign entry_match = entry_full && (entry == stored);

  // NOTE: all state here is sequential, so every assignment in this block is
  // non-blocking; mixing in blocking writes would make ordering matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ENTRY;
      stored     <= '0;
      entry      <= '0;
      digit_cnt  <= '0;
      tries_left <= TRIES_INIT;
      timer      <= '0;
      unlocked   <= 1'b0;
      locked     <= 1'b0;
      error      <= 1'b0;
      set_done   <= 1'b0;
    end else begin
      error    <= 1'b0;
      set_done <= 1'b0;

      if (state == ST_LOCKOUT) begin
        if (timer == TIMER_LAST) begin
          state      <= ST_ENTRY;
          locked     <= 1'b0;
          tries_left <= TRIES_INIT;
        end else begin
          timer <= timer - TIMER_W'(1);
        end
      end else if (clear) begin
        entry     <= '0;
        digit_cnt <= '0;
      end else if (lock) begin
        // lock still shadows submit/code_valid in ENTRY, it just has no effect.
        if (state == ST_OPEN) begin
          state      <= ST_ENTRY;
          unlocked   <= 1'b0;
          entry      <= '0;
          digit_cnt  <= '0;
          tries_left <= TRIES_INIT;
        end
      end else if (submit) begin
        entry     <= '0;
        digit_cnt <= '0;
        if (state == ST_OPEN) begin
          if (entry_full) begin
            stored   <= entry;
            set_done <= 1'b1;
          end else begin
            error <= 1'b1;
          end
        end else if (entry_match) begin
          state      <= ST_OPEN;
          unlocked   <= 1'b1;
          tries_left <= TRIES_INIT;
        end else begin
          error <= 1'b1;
          if (tries_left <= 4'd1) begin
            state      <= ST_LOCKOUT;
            locked     <= 1'b1;
            timer      <= TIMER_INIT;
            tries_left <= '0;
          end else begin
            tries_left <= tries_left - 4'd1;
          end
        end
      end else if (code_valid && legal && (digit_cnt < DIGITS_N)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (digit_cnt == 4'(i)) entry[5*i +: 5] <= code_in;
        end
        digit_cnt <= digit_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_passcode_checker.sv
// Self-checking bench for passcode_checker: a vector table fed through an
// expected-value queue, plus hand-written lockout and reset sequences.
module tb_passcode_checker;

  logic       clk, rst;
  logic [4:0] code_in;
  logic       code_valid, submit, clear, lock;
  logic       unlocked, locked, error, set_done;
  logic [3:0] digit_cnt, tries_left;

  passcode_checker #(.DIGITS(4), .MAX_TRIES(3), .LOCK_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .submit(submit), .clear(clear), .lock(lock), .unlocked(unlocked),
    .locked(locked), .error(error), .set_done(set_done),
    .digit_cnt(digit_cnt), .tries_left(tries_left)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [4:0] C0 = 5'b00000, C1 = 5'b00001, C2 = 5'b10001,
                         C3 = 5'b10010, C4 = 5'b01010;

  // Expected outputs packed as {unlocked, locked, error, set_done, digit_cnt, tries_left}.
  typedef struct {
    logic [4:0]  code;
    logic        valid, sub, clr, lck;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [11:0] sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  function automatic logic [11:0] outs();
    return {unlocked, locked, error, set_done, digit_cnt, tries_left};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [4:0] code, input logic v, s, c, l,
                     input logic u, lk, e, sd, input int cnt, input int tr);
    vec_t x;
    x.code = code; x.valid = v; x.sub = s; x.clr = c; x.lck = l;
    x.exp  = {u, lk, e, sd, 4'(cnt), 4'(tr)};
    vecs.push_back(x);
  endtask

  task automatic idle_inputs();
    code_in = C0; code_valid = 0; submit = 0; clear = 0; lock = 0;
  endtask

  task automatic apply(input vec_t x, input string name);
    logic [11:0] e;
    code_in = x.code; code_valid = x.valid; submit = x.sub; clear = x.clr; lock = x.lck;
    sb.push_back(x.exp);
    @(posedge clk); #1;
    idle_inputs();
    e = sb.pop_front();
    check(name, {20'd0, outs()}, {20'd0, e});
  endtask

  task automatic pulse_submit(input logic [11:0] exp, input string name);
    vec_t x;
    x.code = C0; x.valid = 0; x.sub = 1; x.clr = 0; x.lck = 0; x.exp = exp;
    apply(x, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    bit bad;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {20'd0, outs()}, {20'd0, 12'b0000_0000_0011});
    rst = 1'b0;

    // code, valid, submit, clear, lock | unlocked, locked, error, set_done, cnt, tries
    add(C0, 1,0,0,0, 0,0,0,0, 1,3);
    add(C0, 1,0,0,0, 0,0,0,0, 2,3);
    add(C0, 1,0,0,0, 0,0,0,0, 3,3);
    add(C0, 1,0,0,0, 0,0,0,0, 4,3);
    add(C0, 0,1,0,0, 1,0,0,0, 0,3);  // default 0000 unlocks
    add(C1, 1,0,0,0, 1,0,0,0, 1,3);
    add(C2, 1,0,0,0, 1,0,0,0, 2,3);
    add(C3, 1,0,0,0, 1,0,0,0, 3,3);
    add(C4, 1,0,0,0, 1,0,0,0, 4,3);
    add(C0, 0,1,0,0, 1,0,0,1, 0,3);  // new passcode stored
    add(C0, 0,0,0,1, 0,0,0,0, 0,3);
    add(C1, 1,0,0,0, 0,0,0,0, 1,3);
    add(C2, 1,0,0,0, 0,0,0,0, 2,3);
    add(C3, 1,0,0,0, 0,0,0,0, 3,3);
    add(C4, 1,0,0,0, 0,0,0,0, 4,3);
    add(C0, 0,1,0,0, 1,0,0,0, 0,3);
    add(C0, 0,0,0,1, 0,0,0,0, 0,3);
    add(C0, 1,0,0,0, 0,0,0,0, 1,3);
    add(C0, 1,0,0,0, 0,0,0,0, 2,3);
    add(C0, 1,0,0,0, 0,0,0,0, 3,3);
    add(C0, 1,0,0,0, 0,0,0,0, 4,3);
    add(C0, 0,1,0,0, 0,0,1,0, 0,2);  // old code now wrong
    add(5'b00011, 1,0,0,0, 0,0,0,0, 0,2);
    add(5'b10000, 1,0,0,0, 0,0,0,0, 0,2);
    add(C1, 1,0,0,0, 0,0,0,0, 1,2);
    add(C2, 1,0,0,0, 0,0,0,0, 2,2);
    add(C3, 1,0,0,0, 0,0,0,0, 3,2);
    add(C4, 1,0,0,0, 0,0,0,0, 4,2);
    add(C0, 1,0,0,0, 0,0,0,0, 4,2);  // fifth digit dropped
    add(C0, 0,1,0,0, 1,0,0,0, 0,3);  // buffer intact, so it matches
    add(C0, 0,0,0,1, 0,0,0,0, 0,3);
    add(C1, 1,0,0,0, 0,0,0,0, 1,3);
    add(C2, 1,0,0,0, 0,0,0,0, 2,3);
    add(C3, 1,0,0,0, 0,0,0,0, 3,3);
    add(C4, 1,0,0,0, 0,0,0,0, 4,3);
    add(C0, 0,1,1,0, 0,0,0,0, 0,3);  // clear beats submit
    add(C0, 0,1,0,0, 0,0,1,0, 0,2);  // short entry rejected
    add(C1, 1,0,0,0, 0,0,0,0, 1,2);
    add(C2, 1,0,0,0, 0,0,0,0, 2,2);
    add(C3, 1,0,0,0, 0,0,0,0, 3,2);
    add(C4, 1,0,0,0, 0,0,0,0, 4,2);
    add(C0, 0,1,0,0, 1,0,0,0, 0,3);
    add(C1, 1,0,0,0, 1,0,0,0, 1,3);
    add(C0, 0,1,0,0, 1,0,1,0, 0,3);  // short submit in OPEN: no penalty
    add(C0, 0,0,0,1, 0,0,0,0, 0,3);

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Three failed submits lead into a full-length lockout.
    pulse_submit({4'b0010, 4'd0, 4'd2}, "fail1");
    pulse_submit({4'b0010, 4'd0, 4'd1}, "fail2");
    pulse_submit({4'b0110, 4'd0, 4'd0}, "fail3_lock");
    hi = 1;
    bad = 0;
    for (int i = 1; i < 2000; i++) begin
      code_in = C1; code_valid = i[0]; submit = (i % 3 == 0);
      clear = (i % 5 == 0); lock = (i % 7 == 0);
      @(posedge clk); #1;
      if (!locked) break;
      hi++;
      if (error || set_done || unlocked || digit_cnt != 0) bad = 1;
    end
    idle_inputs();
    check("lockout_len", hi, 1000);
    check("lockout_quiet", {31'd0, bad}, 32'd0);
    check("after_lockout", {20'd0, outs()}, {20'd0, 12'b0000_0000_0011});

    // Reset in the middle of a lockout restores the default passcode.
    pulse_submit({4'b0010, 4'd0, 4'd2}, "rfail1");
    pulse_submit({4'b0010, 4'd0, 4'd1}, "rfail2");
    pulse_submit({4'b0110, 4'd0, 4'd0}, "rfail3");
    hi = 1;
    for (int i = 1; i < 500; i++) begin
      submit = i[0];
      @(posedge clk); #1;
      if (locked) hi++;
    end
    idle_inputs();
    check("locked_before_rst", hi, 500);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_lockout", {20'd0, outs()}, {20'd0, 12'b0000_0000_0011});
    for (int i = 0; i < 4; i++) begin
      vec_t x;
      x.code = C0; x.valid = 1; x.sub = 0; x.clr = 0; x.lck = 0;
      x.exp = {4'b0000, 4'(i + 1), 4'd3};
      apply(x, $sformatf("rst_digit%0d", i));
    end
    pulse_submit({4'b1000, 4'd0, 4'd3}, "rst_default_code");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/passcode_checker.md
Name: passcode_checker

Overview:
- Consumes the 5-bit digit codes produced by the digit encoder, one code per valid strobe, and assembles them into a DIGITS-long entry.
- On submit, compares the entry against a stored passcode and unlocks on match.
- Counts failed attempts; forces a timed lockout after MAX_TRIES failures.
- While unlocked, a full entry plus submit replaces the stored passcode.

Parameters:
- DIGITS, 4, number of digit codes per passcode (2..8)
- MAX_TRIES, 3, failed submits allowed before lockout (1..15)
- LOCK_CYCLES, 1000, clock cycles locked stays high (>=2; sim default, board build overrides)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- code_in  input  5  encoded digit from the encoder
- code_valid  input  1  code_in valid this cycle (1-cycle strobe)
- submit  input  1  1-cycle pulse: check entry (ENTRY state) or store entry (OPEN state)
- clear  input  1  1-cycle pulse: discard current entry, no penalty
- lock  input  1  1-cycle pulse: relock from OPEN
- unlocked  output  1  high while in OPEN
- locked  output  1  high while in LOCKOUT
- error  output  1  1-cycle pulse on a rejected submit
- set_done  output  1  1-cycle pulse when a new passcode is stored
- digit_cnt  output  4  digits currently held in the entry buffer
- tries_left  output  4  remaining attempts before lockout

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=ENTRY; stored passcode = DIGITS copies of 5'b00000 (passcode "0...0").
  - Entry buffer zeroed, digit_cnt=0, tries_left=MAX_TRIES.
  - unlocked=locked=error=set_done=0.
  - Reset asserted mid-lockout or mid-entry overrides everything on that edge.
- Legal codes are exactly: 00000, 00001, 10001, 10010, 01010, 01011, 11011, 11111, 01111, 01110.
  - code_valid with any other code_in is ignored: no count change, no error.
- Entry buffer:
  - Slot i occupies bits [5i+4:5i]; the first digit entered goes to slot 0.
  - A legal code with digit_cnt<DIGITS is written to slot digit_cnt, and digit_cnt increments.
  - A legal code with digit_cnt==DIGITS is dropped (no wrap, no overwrite).
- Same-cycle priority: rst > clear > lock > submit > code_valid. The lower-priority events are dropped that cycle.
- clear: buffer and digit_cnt zeroed next cycle; tries_left unchanged. Ignored in LOCKOUT.
- ENTRY state, on submit:
  - Match (digit_cnt==DIGITS and buffer==stored): go to OPEN, unlocked=1 on the next edge (1-cycle latency), tries_left reloads MAX_TRIES, buffer cleared.
  - Mismatch or short entry: error pulses 1 cycle, buffer cleared, tries_left decrements.
  - If the decrement reaches 0: go to LOCKOUT the same edge, locked=1, timer=LOCK_CYCLES.
  - lock is ignored in ENTRY.
- OPEN state:
  - Code entry works as in ENTRY.
  - submit with digit_cnt==DIGITS: stored passcode <= buffer, set_done pulses, buffer cleared, remain OPEN.
  - submit with a short entry: error pulses; no tries decrement; remain OPEN.
  - lock: go to ENTRY, unlocked=0, buffer cleared, tries_left=MAX_TRIES.
- LOCKOUT state:
  - code_valid, submit, clear and lock are all ignored.
  - The timer decrements every cycle. When it reaches 1, the next edge goes to ENTRY with locked=0 and tries_left=MAX_TRIES.
  - locked is high for exactly LOCK_CYCLES cycles. digit_cnt reads 0 throughout.
- error and set_done are never high in the same cycle.
- unlocked and locked are mutually exclusive.

Test Plan:
- After reset: 4x code 00000, then submit -> unlocked=1 one cycle after submit; tries_left=3; digit_cnt=0.
- From OPEN: enter 00001,10001,10010,01010, then submit -> set_done pulse. Then lock, re-enter the same four codes, submit -> unlocked=1. Entering 0000 instead -> error pulse, tries_left=2.
- Three wrong submits from reset -> error pulses 3 times, tries_left 3->2->1->0, locked=1 for exactly 1000 cycles. Submit during lockout is ignored. Afterwards locked=0, tries_left=3.
- Codes 00011 and 10000 with code_valid -> digit_cnt stays 0. A fifth legal code after 4 -> digit_cnt stays 4 and buffer unchanged.
- clear and submit in the same cycle with a correct full entry -> no unlock, no error, digit_cnt=0, tries_left unchanged.
- rst pulsed at cycle 500 of lockout -> next cycle locked=0, state ENTRY, stored passcode back to 0000, tries_left=3.
